// File: rtl/mtr_shaper_pkg.sv
// Shared types and constants for the motor command shaper.
// Also holds the slew helper used by every channel.
package mtr_shaper_pkg;

  localparam int DUTY_W = 11;
  localparam int CMD_W  = 12;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd2047;

  typedef enum logic [1:0] {
    RUN,
    RAMP_DN,
    DEAD
  } chan_state_e;

  // Moves cur toward goal by at most step; lands exactly on goal when within range.
  function automatic logic [DUTY_W-1:0] slew_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] goal,
                                                    input logic [DUTY_W-1:0] step);
    logic [DUTY_W-1:0] diff;
    if (goal >= cur) begin
      diff = goal - cur;
      slew_toward = (diff > step) ? cur + step : goal;
    end else begin
      diff = cur - goal;
      slew_toward = (diff > step) ? cur - step : goal;
    end
  endfunction

endpackage

// File: rtl/mtr_chan_shaper.sv
// One motor channel: saturation, deadzone offset, slew limit and a forced
// zero-duty dead time before any direction reversal.
module mtr_chan_shaper
  import mtr_shaper_pkg::*;
#(
  parameter int SLEW     = 64,
  parameter int MIN_DUTY = 128,
  parameter int DEAD_CYC = 2048
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pwr_up_i,
  input  logic              cmd_vld_i,
  input  logic [CMD_W-1:0]  cmd_i,
  output logic [DUTY_W-1:0] spd_o,
  output logic              rev_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DEAD_CYC);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DUTY_W-1:0] SLEW_STEP = DUTY_W'(SLEW);
  localparam logic [CMD_W:0]    MIN_OFS   = (CMD_W+1)'(MIN_DUTY);
  localparam logic [CMD_W:0]    SAT_LIM   = (CMD_W+1)'(DUTY_MAX);

  chan_state_e       state_q;
  logic [DUTY_W-1:0] spd_q;
  logic              rev_q;
  logic              pend_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              cmd_dir;
  logic [CMD_W-1:0]  cmd_mag;
  logic [CMD_W:0]    mag_ofs;
  logic [DUTY_W-1:0] cmd_tgt;
  logic [DUTY_W-1:0] spd_tgt_d;
  logic [DUTY_W-1:0] spd_zero_d;

  // Negating -2048 yields itself, so a set MSB after negation means full scale.
  always_comb begin
    cmd_dir = cmd_i[CMD_W-1];
    cmd_mag = cmd_dir ? ((~cmd_i) + 12'd1) : cmd_i;
    if (cmd_mag[CMD_W-1]) cmd_mag = {1'b0, {(CMD_W-1){1'b1}}};
    mag_ofs = {1'b0, cmd_mag} + MIN_OFS;
    if (cmd_mag == '0)          cmd_tgt = '0;
    else if (mag_ofs > SAT_LIM) cmd_tgt = DUTY_MAX;
    else                        cmd_tgt = mag_ofs[DUTY_W-1:0];
    spd_tgt_d  = slew_toward(spd_q, cmd_tgt, SLEW_STEP);
    spd_zero_d = slew_toward(spd_q, '0, SLEW_STEP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || !pwr_up_i) begin
      state_q <= RUN;
      spd_q   <= '0;
      rev_q   <= 1'b0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (cmd_vld_i) begin
            if (cmd_dir == rev_q || cmd_tgt == '0) begin
              spd_q <= spd_tgt_d;
            end else begin
              pend_q <= cmd_dir;
              spd_q  <= spd_zero_d;
              busy_q <= 1'b1;
              if (spd_zero_d == '0) begin
                state_q <= DEAD;
                cnt_q   <= CNT_LOAD;
              end else begin
                state_q <= RAMP_DN;
              end
            end
          end
        end
        RAMP_DN: begin
          if (cmd_vld_i) begin
            if (cmd_dir == rev_q) begin
              state_q <= RUN;
              busy_q  <= 1'b0;
              spd_q   <= spd_tgt_d;
            end else begin
              pend_q <= cmd_dir;
              spd_q  <= spd_zero_d;
              if (spd_zero_d == '0) begin
                state_q <= DEAD;
                cnt_q   <= CNT_LOAD;
              end
            end
          end
        end
        DEAD: begin
          spd_q <= '0;
          // A command arriving on the expiry edge supplies the new direction only.
          if (cnt_q == '0) begin
            rev_q   <= cmd_vld_i ? cmd_dir : pend_q;
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cmd_vld_i) pend_q <= cmd_dir;
          end
        end
        default: begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spd_o  = spd_q;
  assign rev_o  = rev_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/mtr_cmd_shaper.sv
// Shapes signed per-wheel torque commands into duty/direction pairs for mtr_drv.
// Two identical, independent channels share clock, reset, power and strobe.
module mtr_cmd_shaper
  import mtr_shaper_pkg::*;
#(
  parameter int SLEW     = 64,
  parameter int MIN_DUTY = 128,
  parameter int DEAD_CYC = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_up,
  input  logic              cmd_vld,
  input  logic [CMD_W-1:0]  lft_cmd,
  input  logic [CMD_W-1:0]  rght_cmd,
  output logic [DUTY_W-1:0] lft_spd,
  output logic              lft_rev,
  output logic [DUTY_W-1:0] rght_spd,
  output logic              rght_rev,
  output logic              lft_busy,
  output logic              rght_busy
);

  mtr_chan_shaper #(
    .SLEW(SLEW), .MIN_DUTY(MIN_DUTY), .DEAD_CYC(DEAD_CYC)
  ) u_lft (
    .clk_i(clk), .rst_ni(rst_n), .pwr_up_i(pwr_up), .cmd_vld_i(cmd_vld),
    .cmd_i(lft_cmd), .spd_o(lft_spd), .rev_o(lft_rev), .busy_o(lft_busy)
  );

  mtr_chan_shaper #(
    .SLEW(SLEW), .MIN_DUTY(MIN_DUTY), .DEAD_CYC(DEAD_CYC)
  ) u_rght (
    .clk_i(clk), .rst_ni(rst_n), .pwr_up_i(pwr_up), .cmd_vld_i(cmd_vld),
    .cmd_i(rght_cmd), .spd_o(rght_spd), .rev_o(rght_rev), .busy_o(rght_busy)
  );

endmodule

// File: tb/tb_mtr_cmd_shaper.sv
// Self-checking bench for mtr_cmd_shaper: directed sequences, a settle table
// and randomized traffic, all compared against a behavioural model.
module tb_mtr_cmd_shaper;

  localparam int SLEW     = 64;
  localparam int MIN_DUTY = 128;
  localparam int DEAD_CYC = 16;
  localparam int M_RUN = 0, M_RAMP = 1, M_DEAD = 2;

  logic        clk, rst_n, pwr_up, cmd_vld;
  logic [11:0] lft_cmd, rght_cmd;
  logic [10:0] lft_spd, rght_spd;
  logic        lft_rev, rght_rev, lft_busy, rght_busy;

  int errors = 0;
  int checks = 0;

  int mSpd[2];
  bit mRev[2];
  bit mPend[2];
  int mMode[2];
  int mLeft[2];
  bit prevRev[2];

  typedef struct {
    int cmd;
    int expSpd;
    bit expRev;
  } settle_vec_t;
  settle_vec_t vecs[$];

  mtr_cmd_shaper #(.SLEW(SLEW), .MIN_DUTY(MIN_DUTY), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .cmd_vld(cmd_vld),
    .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
    .lft_spd(lft_spd), .lft_rev(lft_rev),
    .rght_spd(rght_spd), .rght_rev(rght_rev),
    .lft_busy(lft_busy), .rght_busy(rght_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] s12(input int v);
    s12 = v[11:0];
  endfunction

  // Duty the spec asks for: saturated magnitude plus deadzone, clipped to 2047.
  function automatic int targetOf(input logic [11:0] c);
    int v, mag;
    v = $signed(c);
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    if (mag == 0) return 0;
    return (mag + MIN_DUTY > 2047) ? 2047 : mag + MIN_DUTY;
  endfunction

  function automatic int toward(input int cur, input int goal);
    if (cur < goal) return (goal - cur > SLEW) ? cur + SLEW : goal;
    return (cur - goal > SLEW) ? cur - SLEW : goal;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mSpd[i] = 0; mRev[i] = 0; mPend[i] = 0; mMode[i] = M_RUN; mLeft[i] = 0;
      prevRev[i] = 0;
    end
  endtask

  task automatic modelStep(input int ch, input bit p, input bit v, input logic [11:0] c);
    bit d;
    int t;
    d = c[11];
    t = targetOf(c);
    if (!p) begin
      mSpd[ch] = 0; mRev[ch] = 0; mMode[ch] = M_RUN; mLeft[ch] = 0;
    end else if (mMode[ch] == M_DEAD) begin
      if (v) mPend[ch] = d;
      mLeft[ch] = mLeft[ch] - 1;
      if (mLeft[ch] == 0) begin
        mRev[ch] = mPend[ch];
        mMode[ch] = M_RUN;
      end
    end else if (v) begin
      if (mMode[ch] == M_RUN && (d == mRev[ch] || t == 0)) begin
        mSpd[ch] = toward(mSpd[ch], t);
      end else if (mMode[ch] == M_RAMP && d == mRev[ch]) begin
        mMode[ch] = M_RUN;
        mSpd[ch] = toward(mSpd[ch], t);
      end else begin
        mPend[ch] = d;
        mSpd[ch] = toward(mSpd[ch], 0);
        mMode[ch] = M_RAMP;
        if (mSpd[ch] == 0) begin
          mMode[ch] = M_DEAD;
          mLeft[ch] = DEAD_CYC;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("lft_spd", lft_spd, mSpd[0]);
    checkVal("lft_rev", lft_rev, mRev[0]);
    checkVal("lft_busy", lft_busy, mMode[0] != M_RUN);
    checkVal("rght_spd", rght_spd, mSpd[1]);
    checkVal("rght_rev", rght_rev, mRev[1]);
    checkVal("rght_busy", rght_busy, mMode[1] != M_RUN);
    if (lft_rev != prevRev[0]) checkVal("lft_rev_flip_spd", lft_spd, 0);
    if (rght_rev != prevRev[1]) checkVal("rght_rev_flip_spd", rght_spd, 0);
    prevRev[0] = lft_rev;
    prevRev[1] = rght_rev;
  endtask

  task automatic applyStimulus(input bit p, input bit v, input logic [11:0] l, input logic [11:0] r);
    pwr_up = p; cmd_vld = v; lft_cmd = l; rght_cmd = r;
    @(posedge clk);
    modelStep(0, p, v, l);
    modelStep(1, p, v, r);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, lft_cmd, rght_cmd);
  endtask

  task automatic hold(input int n, input int l, input int r);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, s12(l), s12(r));
  endtask

  // Counts idle clocks until lft_rev reaches want; bounded so a stuck DUT still ends.
  task automatic measureDead(input bit want, input string name);
    int n;
    n = 0;
    while (n < 100 && lft_rev != want) begin
      idle(1);
      n++;
    end
    checkVal(name, n, DEAD_CYC);
  endtask

  initial begin
    int l, r;
    int stepExp[4];
    rst_n = 1'b0; pwr_up = 1'b0; cmd_vld = 1'b0; lft_cmd = '0; rght_cmd = '0;
    modelReset();
    #12;
    checkVal("rst_lft_spd", lft_spd, 0);
    checkVal("rst_lft_rev", lft_rev, 0);
    checkVal("rst_rght_busy", rght_busy, 0);
    #8 rst_n = 1'b1;

    // Idle with power up: nothing moves without a strobe.
    pwr_up = 1'b1; lft_cmd = s12(500); rght_cmd = s12(-500);
    idle(3);
    checkVal("no_strobe_spd", lft_spd, 0);
    hold(2, 500, -500);
    checkVal("pre_reset_spd", lft_spd, 128);
    #2 rst_n = 1'b0;
    #1;
    checkVal("async_rst_lft_spd", lft_spd, 0);
    checkVal("async_rst_rght_busy", rght_busy, 0);
    modelReset();
    #2 rst_n = 1'b1;
    idle(2);

    // Staircase toward 628 with one command every 4 clocks.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b1, s12(500), s12(0));
      checkVal("stair_spd", lft_spd, (k < 9) ? 64 * (k + 1) : 628);
      checkVal("stair_busy", lft_busy, 0);
      idle(3);
    end

    // Full-scale negative from rest, then +1 and zero.
    hold(12, 0, 0);
    applyStimulus(1'b1, 1'b1, s12(-2048), s12(0));
    checkVal("sat_dead_busy", lft_busy, 1);
    measureDead(1'b1, "sat_dead_len");
    hold(32, -2048, 0);
    checkVal("sat_spd", lft_spd, 2047);
    hold(70, 1, 0);
    checkVal("plus1_spd", lft_spd, 129);
    checkVal("plus1_rev", lft_rev, 0);
    hold(1, 0, 0);
    checkVal("zero_no_min_duty", lft_spd, 65);
    hold(2, 0, 0);
    checkVal("zero_settle", lft_spd, 0);

    // Reversal from 200 forward to -300.
    hold(4, 72, 0);
    checkVal("rev_start_spd", lft_spd, 200);
    stepExp = '{136, 72, 8, 0};
    for (int k = 0; k < 4; k++) begin
      hold(1, -300, 0);
      checkVal("rampdn_spd", lft_spd, stepExp[k]);
      checkVal("rampdn_busy", lft_busy, 1);
    end
    measureDead(1'b1, "rev_dead_len");
    hold(7, -300, 0);
    checkVal("rev_final_spd", lft_spd, 428);

    // Cancelled reversal during ramp-down, then a same-direction command during dead time.
    hold(60, 300, 0);
    checkVal("fwd_spd", lft_spd, 428);
    hold(1, -300, 0);
    checkVal("cancel_ramp_spd", lft_spd, 364);
    hold(1, 300, 0);
    checkVal("cancel_spd", lft_spd, 428);
    checkVal("cancel_busy", lft_busy, 0);
    hold(7, -300, 0);
    checkVal("dead2_busy", lft_busy, 1);
    hold(1, 300, 0);
    idle(20);
    checkVal("dead2_rev", lft_rev, 0);
    checkVal("dead2_busy_end", lft_busy, 0);

    // Right channel runs while left reverses; then power drop in dead time.
    hold(15, 0, 700);
    checkVal("rght_run_spd", rght_spd, 828);
    hold(1, -300, 700);
    measureDead(1'b1, "cross_dead_len");
    hold(1, 300, 700);
    checkVal("pwr_pre_lft_rev", lft_rev, 1);
    checkVal("pwr_pre_lft_busy", lft_busy, 1);
    checkVal("cross_rght_spd", rght_spd, 828);
    checkVal("cross_rght_busy", rght_busy, 0);
    applyStimulus(1'b0, 1'b0, s12(300), s12(700));
    checkVal("pwr_lft_rev", lft_rev, 0);
    checkVal("pwr_lft_busy", lft_busy, 0);
    checkVal("pwr_rght_spd", rght_spd, 0);

    // Settle table: hold each command long enough to finish any reversal.
    vecs.push_back('{500, 628, 1'b0});
    vecs.push_back('{-2048, 2047, 1'b1});
    vecs.push_back('{1, 129, 1'b0});
    vecs.push_back('{0, 0, 1'b0});
    vecs.push_back('{-1, 129, 1'b1});
    vecs.push_back('{0, 0, 1'b1});
    vecs.push_back('{2047, 2047, 1'b0});
    vecs.push_back('{1918, 2046, 1'b0});
    vecs.push_back('{-100, 228, 1'b1});
    vecs.push_back('{1919, 2047, 1'b0});
    foreach (vecs[i]) begin
      hold(90, vecs[i].cmd, -vecs[i].cmd);
      checkVal("tbl_spd", lft_spd, vecs[i].expSpd);
      checkVal("tbl_rev", lft_rev, vecs[i].expRev);
      checkVal("tbl_rght_spd", rght_spd, vecs[i].expSpd);
    end

    // Randomized traffic against the model.
    l = 0; r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        case ($urandom_range(0, 4))
          0: l = -2048;
          1: l = 2047;
          2: l = 0;
          3: l = int'($urandom_range(0, 40)) - 20;
          default: l = int'($urandom_range(0, 4095)) - 2048;
        endcase
      end
      if ($urandom_range(0, 24) == 0) r = int'($urandom_range(0, 4095)) - 2048;
      applyStimulus($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, s12(l), s12(r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mtr_cmd_shaper.md
# mtr_cmd_shaper

Sits directly upstream of the motor driver (`mtr_drv`). It converts the balance controller's signed per-wheel commands into the unsigned 11-bit duty plus direction pair that the driver's PWM stage consumes. Per motor, it applies these steps in order:
- saturation,
- deadzone offset (minimum duty),
- slew-rate limiting,
- an enforced zero-duty dead time before any direction reversal, so the H-bridge never flips polarity while carrying current.

## Interface
Parameters:
- `SLEW`, 64: max change of `*_spd` per accepted command (LSBs of duty)
- `MIN_DUTY`, 128: deadzone offset added to any nonzero magnitude
- `DEAD_CYC`, 2048: clocks of forced zero duty before a direction flip

Ports:
- `clk` in 1: system clock, 50 MHz
- `rst_n` in 1: asynchronous active-low reset
- `pwr_up` in 1: motors enabled; low forces zero duty
- `cmd_vld` in 1: one-clock strobe; `lft_cmd`/`rght_cmd` valid
- `lft_cmd` in 12: signed left torque command (two's complement)
- `rght_cmd` in 12: signed right torque command
- `lft_spd` out 11: left duty to driver
- `lft_rev` out 1: left direction; 1 = reverse
- `rght_spd` out 11: right duty
- `rght_rev` out 1: right direction
- `lft_busy` out 1: left channel in ramp-down or dead time
- `rght_busy` out 1: right channel in ramp-down or dead time

## Operation
- Channels are identical and fully independent.
- Target computation, on `cmd_vld`:
  - dir = cmd[11]; mag = |cmd|.
  - -2048 saturates to mag 2047.
  - tgt = 0 if mag == 0, else min(mag + MIN_DUTY, 2047).
  - Compute in 12-bit unsigned; never wrap.
- Slew: spd moves toward its goal by at most SLEW per accepted `cmd_vld`. It lands exactly on the goal when within SLEW. No overshoot, no underflow below 0.
- FSM states: RUN, RAMP_DN, DEAD.
  - RUN, `cmd_vld`, dir == rev or tgt == 0: slew toward tgt.
  - RUN, `cmd_vld`, dir != rev, spd > 0: latch dir as pend_dir; slew toward 0; go to RAMP_DN. If spd reaches 0 on this step, go to DEAD instead.
  - RUN, `cmd_vld`, dir != rev, spd == 0: latch pend_dir; go to DEAD.
  - RAMP_DN, each `cmd_vld`: refresh pend_dir from the new cmd; slew toward 0; on reaching 0 go to DEAD.
  - If a RAMP_DN command has dir == rev: return to RUN and slew toward the new tgt (reversal cancelled).
  - DEAD: spd held 0. Counter loaded with DEAD_CYC-1 on entry and decrements every clock. `cmd_vld` only refreshes pend_dir.
  - DEAD, counter == 0: rev <= pend_dir; go to RUN. spd stays 0 until the next `cmd_vld`.
- busy = (state != RUN).
- `pwr_up` low, evaluated each clock, overrides everything: spd <= 0, rev <= 0, state RUN, counter 0. Commands are ignored while low.

## Timing
- Reset values: all `*_spd` = 0, `*_rev` = 0, `*_busy` = 0; state RUN; counter 0.
- All outputs are registered. spd/rev/busy reflect a `cmd_vld` on the following clock edge (latency 1).
- Dead time is exactly DEAD_CYC clocks with busy high and spd = 0, measured from the edge entering DEAD to the edge that flips rev.
- Expiry coincides with `cmd_vld`: that command's dir is used for rev; its magnitude is not applied (spd stays 0 that edge).
- rev never changes on an edge where spd is nonzero.
- The only exception is the `pwr_up` drop, which changes rev only together with spd = 0.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous).

## Structure
- `mtr_shaper_pkg`:
  - state enum (RUN, RAMP_DN, DEAD)
  - duty width constant 11
  - command width constant 12
  - DUTY_MAX = 2047
- Sub-module `mtr_chan_shaper`: one channel containing FSM, slew, and dead counter. Instantiated twice (left/right) by `mtr_cmd_shaper`, which only fans out `clk`/`rst_n`/`pwr_up`/`cmd_vld`.
- Dead counter width is $clog2(DEAD_CYC).

## Test plan
1. Assert reset during traffic → all outputs 0 asynchronously. After release, no output change until `cmd_vld` with `pwr_up`=1.
2. lft_cmd = +500, `cmd_vld` every 4 clocks → lft_spd steps 64, 128, …, 576, then 628. lft_rev stays 0; busy stays 0.
3. lft_cmd = -2048 from spd 0, rev 0 → DEAD for DEAD_CYC (bench uses 16) clocks. Then rev = 1, then spd slews to 2047 saturated. lft_cmd = +1 → tgt 129; lft_cmd = 0 → spd slews to 0 with no MIN_DUTY.
4. Reversal: spd 200, rev 0, cmd = -300 → spd 136, 72, 8, 0. busy high from the first step. rev flips exactly DEAD_CYC clocks after spd = 0. Then spd slews to 428. Check rev never toggles with spd ≠ 0.
5. During RAMP_DN send cmd = +300 → reversal cancelled, RUN, spd slews up to 428, rev stays 0. During DEAD send cmd = +300 → counter completes, rev stays 0.
6. `pwr_up` drop in DEAD with rev = 1, spd = 0 → next clock spd 0, rev 0, busy 0. Right channel runs independently and simultaneously (cross-check no coupling).
